// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave receive path.
package spi_pkg;

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      IDLE   = 2'd1,
      ACTIVE = 2'd2
   } spi_state_e;

   // Modes 0 and 3 sample on the rising sck edge, modes 1 and 2 on the falling edge.
   function automatic logic sample_on_rising(input logic cpol, input logic cpha);
      return cpol == cpha;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with synchronous active-high reset.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic [WIDTH-1:0] last_data;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign count   = cnt;
   // The slot under rd_ptr is stale once drained, so the last popped word is kept separately.
   assign rd_data = empty ? last_data : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         last_data <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            last_data <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/spi_slave_rx_fifo.sv
// SPI slave in the system clock domain: oversampled pins, any CPOL/CPHA,
// multi-word frames buffered in a FIFO, MISO driven from tx_word.
module spi_slave_rx_fifo
   import spi_pkg::*;
#(
   parameter int WORD_W      = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cs,
   input  logic                            sck,
   input  logic                            mosi,
   output logic                            miso,
   input  logic [WORD_W-1:0]               tx_word,
   output logic [WORD_W-1:0]               rx_data,
   output logic                            rx_valid,
   input  logic                            rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]     rx_count,
   output logic                            overflow,
   output logic                            frame_err,
   output logic                            busy
);

   localparam int                CNT_W       = $clog2(WORD_W);
   localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(WORD_W - 1);
   localparam logic              SCK_IDLE    = (CPOL != 0);
   localparam logic              SAMPLE_RISE = sample_on_rising(CPOL != 0, CPHA != 0);

   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_prev;
   logic                   cs_s;
   logic                   sck_s;
   logic                   mosi_s;
   logic                   sample_edge;
   logic                   shift_edge;

   spi_state_e             state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [WORD_W-2:0]      rx_shift;
   logic [WORD_W-1:0]      rx_next;
   logic [WORD_W-1:0]      tx_shift;
   logic                   reload;
   logic                   in_frame;
   logic                   word_done;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;

   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // cs resets low so a frame already in progress at reset release is never joined.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_sync   <= '0;
         sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
         mosi_sync <= '0;
         sck_prev  <= SCK_IDLE;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sck_prev  <= sck_s;
      end
   end

   assign sample_edge = SAMPLE_RISE ? (sck_s & ~sck_prev) : (~sck_s & sck_prev);
   assign shift_edge  = SAMPLE_RISE ? (~sck_s & sck_prev) : (sck_s & ~sck_prev);

   assign in_frame  = (state == ACTIVE) && !cs_s;
   assign rx_next   = {rx_shift, mosi_s};
   assign word_done = in_frame && sample_edge && (bit_cnt == LAST_BIT);
   assign pop       = rx_ready & ~fifo_empty;

   // reload marks that the next shift edge starts a new word and must fetch tx_word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARMED;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         reload    <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (word_done && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
         case (state)
            ARMED: begin
               if (cs_s) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (!cs_s) begin
                  state    <= ACTIVE;
                  bit_cnt  <= '0;
                  tx_shift <= tx_word;
                  reload   <= (CPHA != 0);
               end
            end
            ACTIVE: begin
               if (cs_s) begin
                  state     <= IDLE;
                  frame_err <= (bit_cnt != '0);
                  bit_cnt   <= '0;
               end else begin
                  if (sample_edge) begin
                     rx_shift <= rx_next[WORD_W-2:0];
                     if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        reload  <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
                  if (shift_edge) begin
                     if (reload) begin
                        tx_shift <= tx_word;
                        reload   <= 1'b0;
                     end else begin
                        tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
                     end
                  end
               end
            end
            default: state <= ARMED;
         endcase
      end
   end

   assign miso     = (state == ACTIVE) ? tx_shift[WORD_W-1] : 1'b0;
   assign busy     = (state == ACTIVE);
   assign rx_valid = ~fifo_empty;

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (word_done),
      .wr_data (rx_next),
      .pop     (pop),
      .rd_data (rx_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (rx_count)
   );

endmodule
